rca_operand_feeder: RTL and testbench
=====================================

RCA_OPERAND_FEEDER -- requirements
Module: rca_operand_feeder

Interface
REQ-001 Parameter: Nbits, default 64, operand and sum width of the downstream pipelined ripple-carry adder.
REQ-002 Parameter: DEPTH, default 4, operand FIFO entries; power of two, minimum 2.
REQ-003 Parameter: LAT, default 2, downstream adder latency in clk cycles from operand register to valid sum; minimum 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers an operand pair.
REQ-007 in_ready  output  1  feeder can accept a pair this cycle.
REQ-008 in_a  input  Nbits  operand A.
REQ-009 in_b  input  Nbits  operand B.
REQ-010 in_cin  input  1  carry-in for this pair.
REQ-011 stall  input  1  inhibits issue to the adder this cycle.
REQ-012 a  output  Nbits  registered operand A to adder.
REQ-013 b  output  Nbits  registered operand B to adder.
REQ-014 cin  output  1  registered carry-in to adder.
REQ-015 issue_valid  output  1  a, b, cin hold a newly issued pair this cycle.
REQ-016 sum_valid  output  1  adder sum output corresponds to a valid issued pair this cycle.
REQ-017 count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Push occurs when in_valid and in_ready are both 1 at a rising edge; {in_a, in_b, in_cin} written at the tail.
REQ-019 in_ready is 1 iff count < DEPTH, from registered count only; a same-cycle pop never raises in_ready (no full bypass).
REQ-020 Pop/issue occurs at a rising edge when count > 0 and stall = 0; head loaded into a, b, cin and issue_valid set to 1 for the following cycle.
REQ-021 Without a pop, a, b, cin hold their previous values and issue_valid is 0 for the following cycle.
REQ-022 No empty bypass: a pair pushed at edge k is issued no earlier than edge k+1; issue_valid no earlier than the cycle after edge k+1.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both operations performed.
REQ-024 Push only: count +1; pop only: count -1; neither or both: count unchanged.
REQ-025 Read and write pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-026 Pairs issue in strict push order; no pair dropped or duplicated.
REQ-027 in_valid while in_ready = 0 has no effect; upstream holds the pair until accepted.
REQ-028 sum_valid equals issue_valid delayed by exactly LAT cycles via a LAT-stage shift register; it advances every cycle regardless of stall.
REQ-029 stall affects only issue; pushes continue until full.

Reset
REQ-030 With rst = 1 at a rising edge: pointers, count, a, b, cin, issue_valid and all sum_valid shift stages cleared to 0.
REQ-031 in_ready is 1 in the cycle after reset (count = 0).
REQ-032 Reset mid-operation discards all buffered and in-flight pairs; a push presented in the reset cycle is not accepted; sum_valid is 0 for at least LAT cycles after reset.
REQ-033 FIFO storage array needs no reset; contents never reach outputs without a valid pop.

Verification
REQ-034 Single pair: push a=1, b=1, cin=0 at edge 1, stall=0 -> issue_valid=1 after edge 2 with a=1, b=1; sum_valid=1 after edge 4 (LAT=2); adder sum=2.
REQ-035 Fill: stall=1, push 5 pairs back-to-back -> first 4 accepted, count=4, in_ready=0, 5th held; release stall -> issue order 0xFFFFFFFF+1, 0x0F0F..+0xF0F0.., 0xFFFF..FF+1, 0xAAAA..+0x5555..; sums 0x1_0000_0000, all-F, 0 (carry lost), all-F.
REQ-036 Steady stream at full with stall=0, in_valid=1 every cycle -> one pair issued per cycle after initial fill, count stable, pointers wrap past 3 to 0 with no reorder over 16 pairs.
REQ-037 Stall toggling every other cycle with continuous input -> issue_valid alternates, sum_valid pattern equals issue_valid shifted by LAT, no loss or duplication.
REQ-038 Reset with count=3 and 2 pairs in flight -> after edge, count=0, issue_valid=0, sum_valid=0 for next 2 cycles, in_ready=1; next pushed pair issues correctly.
REQ-039 Push and pop same edge at count=2 -> count stays 2, issued pair is oldest.

Source files
------------

// File: rtl/rca_operand_feeder.sv
// Operand FIFO feeding a LAT-cycle pipelined ripple-carry adder; a pair pushed at edge k issues at edge k+1 at the earliest, and sum_valid trails issue_valid by LAT cycles.
// in_ready depends only on registered occupancy (no full bypass); stall holds issue while pushes continue until the FIFO is full.
module rca_operand_feeder #(
  parameter int Nbits = 64,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Nbits-1:0]         in_a,
  input  logic [Nbits-1:0]         in_b,
  input  logic                     in_cin,
  input  logic                     stall,
  output logic [Nbits-1:0]         a,
  output logic [Nbits-1:0]         b,
  output logic                     cin,
  output logic                     issue_valid,
  output logic                     sum_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [Nbits-1:0] a;
    logic [Nbits-1:0] b;
    logic             cin;
  } pair_t;

  pair_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  pair_t          op_q, op_d;
  logic           issue_q, issue_d;
  logic [LAT-1:0] sv_q, sv_d;
  logic           push, pop;

  assign in_ready = (count_q < FULL);
  assign push     = in_valid & in_ready;
  assign pop      = (count_q != '0) & ~stall;

  // DEPTH is a power of two, so the pointers wrap naturally at their width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    op_d     = op_q;
    issue_d  = 1'b0;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      op_d     = mem_q[rd_ptr_q];
      issue_d  = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    sv_d = (sv_q << 1) | LAT'(issue_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      op_q     <= '0;
      issue_q  <= 1'b0;
      sv_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      op_q     <= op_d;
      issue_q  <= issue_d;
      sv_q     <= sv_d;
    end
  end

  // Storage is unreset: an entry only reaches the outputs through a pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: in_a, b: in_b, cin: in_cin};
    end
  end

  assign a           = op_q.a;
  assign b           = op_q.b;
  assign cin         = op_q.cin;
  assign issue_valid = issue_q;
  assign sum_valid   = sv_q[LAT-1];
  assign count       = count_q;

endmodule

// File: tb/tb_rca_operand_feeder.sv
// Directed bench for rca_operand_feeder (Nbits=64, DEPTH=4, LAT=2).
module tb_rca_operand_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a, in_b;
  logic        in_cin;
  logic        stall;
  logic [63:0] a, b;
  logic        cin, issue_valid, sum_valid;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rca_operand_feeder #(.Nbits(64), .DEPTH(4), .LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .stall(stall),
    .a(a), .b(b), .cin(cin), .issue_valid(issue_valid),
    .sum_valid(sum_valid), .count(count)
  );

  function automatic logic [63:0] tag_a(int t);
    return {32'hA5A5_0000, t[31:0]};
  endfunction

  function automatic logic [63:0] tag_b(int t);
    return {t[31:0], 32'h5A5A_0000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tag(int t);
    in_a   = tag_a(t);
    in_b   = tag_b(t);
    in_cin = t[0];
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %b want 0", issue_valid); else n_pass++;
    n_checks++; if (sum_valid !== 1'b0) $display("FAIL reset_sum_valid: got %b want 0", sum_valid); else n_pass++;
    n_checks++; if ({a, b, cin} !== 129'd0) $display("FAIL reset_operands: got a=%0h b=%0h cin=%b want 0", a, b, cin); else n_pass++;
  endtask

  task automatic test_single();
    logic [63:0] s;
    in_valid = 1'b1; in_a = 64'd1; in_b = 64'd1; in_cin = 1'b0;
    step();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1) $display("FAIL single_count_after_push: got %0d want 1", count); else n_pass++;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL single_no_bypass: got %b want 0", issue_valid); else n_pass++;
    step();
    n_checks++; if (issue_valid !== 1'b1) $display("FAIL single_issue: got %b want 1", issue_valid); else n_pass++;
    n_checks++; if (a !== 64'd1 || b !== 64'd1 || cin !== 1'b0) $display("FAIL single_operands: got a=%0h b=%0h cin=%b want 1 1 0", a, b, cin); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL single_count_after_pop: got %0d want 0", count); else n_pass++;
    step();
    n_checks++; if (issue_valid !== 1'b0 || sum_valid !== 1'b0) $display("FAIL single_edge3: got iv=%b sv=%b want 0 0", issue_valid, sum_valid); else n_pass++;
    step();
    s = a + b + 64'(cin);
    n_checks++; if (sum_valid !== 1'b1) $display("FAIL single_sum_valid: got %b want 1", sum_valid); else n_pass++;
    n_checks++; if (s !== 64'd2) $display("FAIL single_sum: got %0h want 2", s); else n_pass++;
    step();
    n_checks++; if (sum_valid !== 1'b0) $display("FAIL single_sum_valid_drop: got %b want 0", sum_valid); else n_pass++;
  endtask

  task automatic test_fill();
    logic [63:0] pa [5] = '{64'hFFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'hAAAA_AAAA_AAAA_AAAA, 64'h1234};
    logic [63:0] pb [5] = '{64'd1, 64'hF0F0_F0F0_F0F0_F0F0, 64'd1, 64'h5555_5555_5555_5555, 64'h10};
    logic        pc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] ps [5] = '{64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                            64'hFFFF_FFFF_FFFF_FFFF, 64'h1245};
    int          ec [5] = '{3, 3, 2, 1, 0};
    logic [63:0] s;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = pa[i]; in_b = pb[i]; in_cin = pc[i];
      step();
    end
    n_checks++; if (count !== 3'd4) $display("FAIL fill_count: got %0d want 4", count); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL fill_stalled_issue: got %b want 0", issue_valid); else n_pass++;
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) in_valid = 1'b0;
      s = a + b + 64'(cin);
      n_checks++; if (issue_valid !== 1'b1) $display("FAIL fill_issue_%0d: got %b want 1", k, issue_valid); else n_pass++;
      n_checks++; if (a !== pa[k] || b !== pb[k] || cin !== pc[k]) $display("FAIL fill_order_%0d: got a=%0h b=%0h cin=%b want a=%0h b=%0h cin=%b", k, a, b, cin, pa[k], pb[k], pc[k]); else n_pass++;
      n_checks++; if (s !== ps[k]) $display("FAIL fill_sum_%0d: got %0h want %0h", k, s, ps[k]); else n_pass++;
      n_checks++; if (count !== 3'(ec[k])) $display("FAIL fill_count_%0d: got %0d want %0d", k, count, ec[k]); else n_pass++;
    end
    step(); step(); step();
  endtask

  task automatic test_stream();
    int  nxt = 0;
    int  exp_t = 0;
    logic rdy;
    stall = 1'b1; in_valid = 1'b1; drive_tag(nxt);
    for (int i = 0; i < 5; i++) begin
      rdy = in_ready;
      step();
      if (rdy) begin nxt++; drive_tag(nxt); end
    end
    n_checks++; if (count !== 3'd4 || in_ready !== 1'b0) $display("FAIL stream_fill: got count=%0d rdy=%b want 4 0", count, in_ready); else n_pass++;
    stall = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rdy = in_ready;
      step();
      if (in_valid && rdy) begin
        nxt++;
        if (nxt == 16) in_valid = 1'b0; else drive_tag(nxt);
      end
      n_checks++; if (issue_valid !== 1'b1) $display("FAIL stream_issue_%0d: got %b want 1", k, issue_valid); else n_pass++;
      n_checks++; if (a !== tag_a(exp_t) || b !== tag_b(exp_t) || cin !== exp_t[0]) $display("FAIL stream_order_%0d: got a=%0h want %0h", k, a, tag_a(exp_t)); else n_pass++;
      n_checks++; if (count !== 3'((k <= 12) ? 3 : 15 - k)) $display("FAIL stream_count_%0d: got %0d want %0d", k, count, (k <= 12) ? 3 : 15 - k); else n_pass++;
      exp_t++;
    end
    step(); step(); step();
  endtask

  task automatic test_stall_toggle();
    int   nxt = 200;
    int   exp_t = 200;
    logic rdy;
    in_valid = 1'b1; drive_tag(nxt);
    for (int j = 0; j < 26; j++) begin
      stall = (j < 20) ? j[0] : 1'b0;
      if (j == 20) in_valid = 1'b0;
      rdy = in_ready;
      step();
      if (in_valid && rdy) begin nxt++; drive_tag(nxt); end
      if (j < 20) begin
        n_checks++; if (issue_valid !== ((j >= 2) && !j[0])) $display("FAIL toggle_issue_%0d: got %b want %b", j, issue_valid, (j >= 2) && !j[0]); else n_pass++;
        n_checks++; if (sum_valid !== ((j >= 4) && !j[0])) $display("FAIL toggle_sum_valid_%0d: got %b want %b", j, sum_valid, (j >= 4) && !j[0]); else n_pass++;
      end
      if (issue_valid) begin
        n_checks++; if (a !== tag_a(exp_t) || b !== tag_b(exp_t) || cin !== exp_t[0]) $display("FAIL toggle_order_%0d: got a=%0h want %0h", j, a, tag_a(exp_t)); else n_pass++;
        exp_t++;
      end
    end
    n_checks++; if (exp_t !== nxt) $display("FAIL toggle_loss: got %0d issued want %0d pushed", exp_t - 200, nxt - 200); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL toggle_drain_count: got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   nxt = 300;
    logic rdy;
    stall = 1'b1; in_valid = 1'b1; drive_tag(nxt);
    for (int i = 0; i < 5; i++) begin
      rdy = in_ready;
      step();
      if (rdy) begin nxt++; drive_tag(nxt); end
    end
    stall = 1'b0;
    step(); step();
    n_checks++; if (count !== 3'd3 || issue_valid !== 1'b1) $display("FAIL rstmid_setup: got count=%0d iv=%b want 3 1", count, issue_valid); else n_pass++;
    rst = 1'b1; in_valid = 1'b1; in_a = 64'hDEAD; in_b = 64'hBEEF; in_cin = 1'b1;
    step();
    n_checks++; if (count !== 3'd0) $display("FAIL rstmid_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (issue_valid !== 1'b0 || sum_valid !== 1'b0) $display("FAIL rstmid_valids: got iv=%b sv=%b want 0 0", issue_valid, sum_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
    step();
    n_checks++; if (sum_valid !== 1'b0) $display("FAIL rstmid_sv_1: got %b want 0", sum_valid); else n_pass++;
    step();
    n_checks++; if (sum_valid !== 1'b0 || issue_valid !== 1'b0) $display("FAIL rstmid_sv_2: got sv=%b iv=%b want 0 0", sum_valid, issue_valid); else n_pass++;
    in_valid = 1'b1; in_a = 64'd7; in_b = 64'd8; in_cin = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_checks++; if (issue_valid !== 1'b1 || a !== 64'd7 || b !== 64'd8 || cin !== 1'b1) $display("FAIL rstmid_next_pair: got iv=%b a=%0h b=%0h cin=%b want 1 7 8 1", issue_valid, a, b, cin); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL rstmid_next_count: got %0d want 0", count); else n_pass++;
    step(); step();
    n_checks++; if (sum_valid !== 1'b1) $display("FAIL rstmid_next_sv: got %b want 1", sum_valid); else n_pass++;
    step();
  endtask

  task automatic test_push_pop();
    stall = 1'b1; in_valid = 1'b1; drive_tag(400);
    step();
    drive_tag(401);
    step();
    drive_tag(402);
    stall = 1'b0;
    n_checks++; if (count !== 3'd2) $display("FAIL pp_setup_count: got %0d want 2", count); else n_pass++;
    step();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd2) $display("FAIL pp_count: got %0d want 2", count); else n_pass++;
    n_checks++; if (issue_valid !== 1'b1 || a !== tag_a(400) || b !== tag_b(400) || cin !== 1'b0) $display("FAIL pp_oldest: got iv=%b a=%0h want 1 %0h", issue_valid, a, tag_a(400)); else n_pass++;
    step();
    n_checks++; if (a !== tag_a(401) || count !== 3'd1) $display("FAIL pp_second: got a=%0h count=%0d want %0h 1", a, count, tag_a(401)); else n_pass++;
    step();
    n_checks++; if (a !== tag_a(402) || count !== 3'd0) $display("FAIL pp_third: got a=%0h count=%0d want %0h 0", a, count, tag_a(402)); else n_pass++;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_stall_toggle();
    test_reset_mid();
    test_push_pop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
